// File: rtl/unidade_controle.sv
// Control FSM for the 16-bit processor datapath: sequences instruction load,
// register-file access, ALU operation, ALU-result capture and write-back.
module unidade_controle #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Run,
  input  logic [DATA_WIDTH-1:0]     instruction,
  output logic                      irLoad,
  output logic                      aluRegLoad,
  output logic [1:0]                controlUla,
  output logic [1:0]                controlMux,
  output logic [REG_ADDR_WIDTH-1:0] readAddr1,
  output logic [REG_ADDR_WIDTH-1:0] readAddr2,
  output logic [REG_ADDR_WIDTH-1:0] writeAddr,
  output logic                      writeEnable,
  output logic                      Done,
  output logic                      Busy,
  output logic                      Invalid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] MUX_RF1 = 2'b00;
  localparam logic [1:0] MUX_IN  = 2'b10;
  localparam logic [1:0] MUX_ALU = 2'b11;

  state_t state_reg, state_next;

  logic [2:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rx;
  logic [REG_ADDR_WIDTH-1:0] ry;
  logic                      unused_bits;

  assign op = instruction[DATA_WIDTH-1 -: 3];
  assign rx = instruction[DATA_WIDTH-4 -: REG_ADDR_WIDTH];
  assign ry = instruction[DATA_WIDTH-4-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
  assign unused_bits = ^instruction[DATA_WIDTH-4-2*REG_ADDR_WIDTH:0];

  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    irLoad      = 1'b0;
    aluRegLoad  = 1'b0;
    controlUla  = 2'b00;
    controlMux  = MUX_RF1;
    readAddr1   = '0;
    readAddr2   = '0;
    writeAddr   = '0;
    writeEnable = 1'b0;
    Done        = 1'b0;
    Busy        = 1'b0;
    Invalid     = 1'b0;

    // Reset masks every output so an interrupted instruction never writes back.
    if (!Reset) begin
      Busy = (state_reg != S_IDLE);
      case (state_reg)
        S_IDLE: begin
          if (Run) begin
            irLoad     = 1'b1;
            state_next = S_EXEC1;
          end
        end
        S_EXEC1: begin
          case (op)
            OP_MV: begin
              readAddr1   = ry;
              controlMux  = MUX_RF1;
              writeAddr   = rx;
              writeEnable = 1'b1;
              Done        = 1'b1;
              state_next  = S_IDLE;
            end
            OP_MVI: begin
              controlMux  = MUX_IN;
              writeAddr   = rx;
              writeEnable = 1'b1;
              Done        = 1'b1;
              state_next  = S_IDLE;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              readAddr1  = rx;
              readAddr2  = ry;
              // add/sub/and/or are consecutive opcodes starting at 010.
              controlUla = op[1:0] - 2'b10;
              aluRegLoad = 1'b1;
              state_next = S_EXEC2;
            end
            default: begin
              Done       = 1'b1;
              Invalid    = 1'b1;
              state_next = S_IDLE;
            end
          endcase
        end
        S_EXEC2: begin
          controlMux  = MUX_ALU;
          writeAddr   = rx;
          writeEnable = 1'b1;
          Done        = 1'b1;
          state_next  = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed per-cycle vectors for unidade_controle; expected output words are
// queued by the stimulus and checked by an independent monitor each cycle.
module tb_unidade_controle;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] instruction;
  logic        irLoad, aluRegLoad, writeEnable, Done, Busy, Invalid;
  logic [1:0]  controlUla, controlMux;
  logic [2:0]  readAddr1, readAddr2, writeAddr;

  unidade_controle #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .instruction(instruction),
    .irLoad(irLoad), .aluRegLoad(aluRegLoad), .controlUla(controlUla),
    .controlMux(controlMux), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .writeAddr(writeAddr), .writeEnable(writeEnable), .Done(Done),
    .Busy(Busy), .Invalid(Invalid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Output word: irLoad aluRegLoad ula mux ra1 ra2 wa we done busy invalid
  function automatic logic [18:0] mk(input logic ir, input logic alu,
                                     input logic [1:0] ula, input logic [1:0] mux,
                                     input logic [2:0] ra1, input logic [2:0] ra2,
                                     input logic [2:0] wa, input logic we,
                                     input logic dn, input logic bsy, input logic inv);
    return {ir, alu, ula, mux, ra1, ra2, wa, we, dn, bsy, inv};
  endfunction

  localparam logic [18:0] DEF = 19'h0;

  task automatic step(input string nm, input logic rst, input logic run,
                      input logic [15:0] instr, input logic [18:0] e);
    @(posedge Clock);
    #1;
    Reset       = rst;
    Run         = run;
    instruction = instr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the combinational outputs mid-cycle against the queue.
  initial begin
    logic [18:0] act, e;
    string       nm;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {irLoad, aluRegLoad, controlUla, controlMux, readAddr1, readAddr2,
               writeAddr, writeEnable, Done, Busy, Invalid};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %05h expected %05h", nm, act, e);
        end else begin
          $display("vec %0d %s: outputs %05h ok", vectors, nm, act);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    Reset = 1'b1;
    Run = 1'b0;
    instruction = 16'h0000;

    step("reset", 1, 0, 16'h0000, DEF);
    step("reset_run", 1, 1, 16'h2C00, DEF);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 16'h0000, DEF);

    // mvi R3
    step("mvi_c0", 0, 1, 16'h2C00, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("mvi_c1", 0, 0, 16'h2C00, mk(0,0,2'b00,2'b10,0,0,3,1,1,1,0));
    step("mvi_c2", 0, 0, 16'h2C00, DEF);

    // mv R1,R3
    step("mv_c0", 0, 1, 16'h0580, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("mv_c1", 0, 0, 16'h0580, mk(0,0,2'b00,2'b00,3,0,1,1,1,1,0));

    // sub R3,R1 with Run high in EXEC2 (ignored)
    step("sub_c0", 0, 1, 16'h6C80, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("sub_c1", 0, 0, 16'h6C80, mk(0,1,2'b01,2'b00,3,1,0,0,0,1,0));
    step("sub_c2", 0, 1, 16'h6C80, mk(0,0,2'b00,2'b11,0,0,3,1,1,1,0));
    step("sub_c3", 0, 0, 16'h6C80, DEF);

    // add R2,R2
    step("add_c0", 0, 1, 16'h4900, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("add_c1", 0, 0, 16'h4900, mk(0,1,2'b00,2'b00,2,2,0,0,0,1,0));
    step("add_c2", 0, 0, 16'h4900, mk(0,0,2'b00,2'b11,0,0,2,1,1,1,0));

    // and R4,R6
    step("and_c0", 0, 1, 16'h9300, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("and_c1", 0, 0, 16'h9300, mk(0,1,2'b10,2'b00,4,6,0,0,0,1,0));
    step("and_c2", 0, 0, 16'h9300, mk(0,0,2'b00,2'b11,0,0,4,1,1,1,0));

    // or R7,R5
    step("or_c0", 0, 1, 16'hBE80, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("or_c1", 0, 0, 16'hBE80, mk(0,1,2'b11,2'b00,7,5,0,0,0,1,0));
    step("or_c2", 0, 0, 16'hBE80, mk(0,0,2'b00,2'b11,0,0,7,1,1,1,0));

    // reserved 111 with Run held, then back-to-back mv R1,R3
    step("rsv7_c0", 0, 1, 16'hE000, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("rsv7_c1", 0, 1, 16'hE000, mk(0,0,2'b00,2'b00,0,0,0,0,1,1,1));
    step("rsv7_c2", 0, 1, 16'h0580, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("b2b_mv_c1", 0, 0, 16'h0580, mk(0,0,2'b00,2'b00,3,0,1,1,1,1,0));

    // reserved 110
    step("rsv6_c0", 0, 1, 16'hC000, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("rsv6_c1", 0, 0, 16'hC000, mk(0,0,2'b00,2'b00,0,0,0,0,1,1,1));

    // add R0,R1 interrupted by reset in EXEC1
    step("rstx1_c0", 0, 1, 16'h4080, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("rstx1_c1", 1, 0, 16'h4080, DEF);
    step("rstx1_c2", 0, 0, 16'h4080, DEF);
    step("rstx1_c3", 0, 0, 16'h4080, DEF);

    // sub R3,R1 interrupted by reset in EXEC2
    step("rstx2_c0", 0, 1, 16'h6C80, mk(1,0,2'b00,2'b00,0,0,0,0,0,0,0));
    step("rstx2_c1", 0, 0, 16'h6C80, mk(0,1,2'b01,2'b00,3,1,0,0,0,1,0));
    step("rstx2_c2", 1, 1, 16'h6C80, DEF);
    step("rstx2_c3", 0, 0, 16'h6C80, DEF);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge Clock);
      wait_cycles++;
    end
    @(posedge Clock);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Control FSM for the 16-bit processor datapath. Replaces the externally driven controlUla, controlMux and readWriteReg signals.
- Sequences instruction load, register-file read/write, ALU operation, ALU-result register load and write-back mux selection.
- Sits directly upstream of the datapath: consumes the instruction register contents and drives every datapath control input.

Parameters:
- DATA_WIDTH, 16, instruction/data word width.
- REG_ADDR_WIDTH, 3, register-file address width (8 registers).

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  request to start the next instruction; sampled only in S_IDLE.
- instruction  input  DATA_WIDTH  current instruction register output.
- irLoad  output  1  instruction register load enable (datapath IR enable is wired to this).
- aluRegLoad  output  1  ALU result register load enable.
- controlUla  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- controlMux  output  2  write-back source: 00 dataRFOut1, 01 dataRFOut2, 10 dataIn, 11 DataOutRegAlu.
- readAddr1  output  REG_ADDR_WIDTH  register-file read port 1 address.
- readAddr2  output  REG_ADDR_WIDTH  register-file read port 2 address.
- writeAddr  output  REG_ADDR_WIDTH  register-file write address.
- writeEnable  output  1  register-file write enable.
- Done  output  1  one-cycle pulse in the final cycle of every instruction.
- Busy  output  1  high whenever state is not S_IDLE.
- Invalid  output  1  one-cycle pulse when a reserved opcode completes.

Behaviour:
- Instruction format: op=instruction[15:13], rx=[12:10], ry=[9:7]; [6:0] ignored.
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#imm (imm on dataIn in the execute cycle); 010 add; 011 sub; 100 and; 101 or (Rx <= Rx op Ry); 110/111 reserved.
- Register-file reads are combinational. The ALU result register captures on the edge where aluRegLoad=1.
- States: S_IDLE, S_EXEC1, S_EXEC2. State register is the only sequential element; outputs decode combinationally from state, instruction and Run.
- Default outputs, and all outputs during the reset cycle and in S_IDLE without Run: every enable, Done and Invalid = 0; controlUla=00, controlMux=00, all addresses 0.
- S_IDLE:
  - Run=1: irLoad=1, next S_EXEC1.
  - Run=0: remain.
- S_EXEC1, keyed on op:
  - mv: readAddr1=ry, controlMux=00, writeAddr=rx, writeEnable=1, Done=1, next S_IDLE.
  - mvi: controlMux=10, writeAddr=rx, writeEnable=1, Done=1, next S_IDLE.
  - ALU ops: readAddr1=rx, readAddr2=ry, controlUla=op-010, aluRegLoad=1, next S_EXEC2.
  - reserved: no enables, Done=1, Invalid=1, next S_IDLE.
- S_EXEC2: controlMux=11, writeAddr=rx, writeEnable=1, Done=1, next S_IDLE.
- Latency from Run sampled in S_IDLE:
  - mv/mvi/reserved: Done 1 cycle later (2-cycle instruction).
  - ALU ops: Done 2 cycles later (3-cycle instruction).
- Run outside S_IDLE is ignored. With Run held high, the next irLoad occurs in the cycle after Done (back-to-back, no bubble beyond the return to S_IDLE).
- The instruction input must stay stable from S_EXEC1 through Done. irLoad is never asserted outside S_IDLE.
- Reset mid-instruction: at the next rising edge with Reset=1, state goes to S_IDLE. While Reset=1, all outputs are forced to defaults regardless of state, so no partial write-back occurs.
- Reset and Run high together: Reset wins; irLoad=0.
- rx==ry is legal (e.g. add R2,R2 doubles R2). mv Rx,Rx writes the unchanged value.

Test Plan:
- Reset, then Run=0 for 5 cycles -> Busy=0, Done=0, writeEnable=0, irLoad=0 every cycle.
- mvi R3,#0x00AB (instruction 0x2C00, dataIn=0x00AB in S_EXEC1) with Run pulse -> irLoad=1 in cycle 0; in cycle 1 controlMux=10, writeAddr=3, writeEnable=1, Done=1; Busy=0 in cycle 2.
- mv R1,R3 (0x0580) -> cycle 1: readAddr1=3, controlMux=00, writeAddr=1, writeEnable=1, Done=1.
- sub R3,R1 (0x6C80) -> cycle 1: readAddr1=3, readAddr2=1, controlUla=01, aluRegLoad=1, Done=0; cycle 2: controlMux=11, writeAddr=3, writeEnable=1, Done=1.
- Opcode 111 (0xE000) with Run held high -> cycle 1: Invalid=1, Done=1, no enables; cycle 2: irLoad=1 immediately for the next instruction.
- add R0,R1 (0x4080), Reset asserted in S_EXEC1 -> writeEnable never asserted for that instruction; state S_IDLE after the edge; outputs at defaults.
